ahb_lite_sram_slave: RTL

//  AHB-Lite slave: single-port SRAM target behind the dut_if master bus. Consumes master address/data

---
 rtl/ahb_lite_sram_slave.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave: byte-lane writes, full-word reads, two-cycle ERROR response.
// Define AHB_SLV_WAIT_EN to insert WAIT_STATES wait cycles before every good data phase.
module ahb_lite_sram_slave #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RW          = 2,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [DW-1:0] hwdata,
    input  logic          error,
    output logic [DW-1:0] hrdata,
    output logic          hready,
    output logic [RW-1:0] hresp
);
    localparam int NB      = DW / 8;
    localparam int LGB     = $clog2(NB);
    localparam int ADDR_LG = $clog2(DEPTH * NB);
    localparam int IDXW    = ADDR_LG - LGB;
    localparam logic [RW-1:0] RESP_OKAY  = RW'(2'b00);
    localparam logic [RW-1:0] RESP_ERROR = RW'(2'b01);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_ERR1 = 3'd2,
        ST_ERR2 = 3'd3
`ifdef AHB_SLV_WAIT_EN
        , ST_WAIT = 3'd4
`endif
    } state_t;

    function automatic logic f_misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = addr_lo[0];
            3'd2:    bad = |addr_lo[1:0];
            3'd3:    bad = |addr_lo[2:0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [NB-1:0] f_lane_mask(input logic [LGB-1:0] off, input logic [2:0] size);
        logic [NB-1:0] mask;
        int unsigned   lo;
        int unsigned   hi;
        lo = 32'(off);
        hi = lo + (32'd1 << size);
        for (int k = 0; k < NB; k++) begin
            mask[k] = (32'(k) >= lo) && (32'(k) < hi);
        end
        return mask;
    endfunction

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                              input logic [NB-1:0] mask);
        logic [DW-1:0] res;
        for (int k = 0; k < NB; k++) begin
            if (mask[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_w[8*k +: 8];
            end
        end
        return res;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_LG-1:0] r_addr;
    logic               r_write;
    logic [2:0]         r_size;
    logic               r_hready;
    logic [RW-1:0]      r_hresp;
    logic [DW-1:0]      r_hrdata;
    logic [DW-1:0]      r_mem [DEPTH];

    logic               w_accept;
    logic               w_err;
    logic               w_wr_en;
    logic [IDXW-1:0]    w_wr_idx;
    logic [NB-1:0]      w_wr_mask;
    logic [IDXW-1:0]    w_rd_idx;
    logic               w_rd_is_read;
    logic [DW-1:0]      w_rd_word;
    logic               w_hready_nxt;
    logic [RW-1:0]      w_hresp_nxt;
    logic [DW-1:0]      w_hrdata_nxt;
    logic               w_unused;

    assign w_unused = ^{htrans[0], hburst, hprot};

`ifdef AHB_SLV_WAIT_EN
    localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    logic [WCW-1:0] r_wait_cnt;
    logic [WCW-1:0] w_wait_cnt_nxt;
`else
    logic [31:0] w_unused_ws;
    assign w_unused_ws = 32'(WAIT_STATES);
`endif

    assign w_accept  = hsel & htrans[1] & r_hready;
    assign w_err     = error | f_misaligned(haddr[2:0], hsize) | (hsize > 3'(LGB))
                     | ((haddr >> ADDR_LG) != {AW{1'b0}});
    assign w_wr_en   = (r_state == ST_DATA) & r_write;
    assign w_wr_idx  = r_addr[ADDR_LG-1:LGB];
    assign w_wr_mask = f_lane_mask(r_addr[LGB-1:0], r_size);

    // Next state: a new address phase can only be taken while hready is high.
    always_comb begin
        w_state_nxt = r_state;
`ifdef AHB_SLV_WAIT_EN
        w_wait_cnt_nxt = r_wait_cnt;
`endif
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (w_accept && w_err) begin
                    w_state_nxt = ST_ERR1;
                end else if (w_accept) begin
`ifdef AHB_SLV_WAIT_EN
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt    = ST_WAIT;
                        w_wait_cnt_nxt = WCW'(WAIT_STATES);
                    end
`else
                    w_state_nxt = ST_DATA;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
                if (r_wait_cnt <= WCW'(1)) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt    = ST_WAIT;
                    w_wait_cnt_nxt = r_wait_cnt - WCW'(1);
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read data for the coming data phase; forwards a write committing on the same edge.
    always_comb begin
        w_rd_idx     = w_wr_idx;
        w_rd_is_read = ~r_write;
        if (w_accept) begin
            w_rd_idx     = haddr[ADDR_LG-1:LGB];
            w_rd_is_read = ~hwrite;
        end else begin
            w_rd_idx     = w_wr_idx;
            w_rd_is_read = ~r_write;
        end
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
            w_rd_word = f_merge(r_mem[w_rd_idx], hwdata, w_wr_mask);
        end else begin
            w_rd_word = r_mem[w_rd_idx];
        end
        if ((w_state_nxt == ST_DATA) && w_rd_is_read) begin
            w_hrdata_nxt = w_rd_word;
        end else begin
            w_hrdata_nxt = {DW{1'b0}};
        end
    end

    always_comb begin
        w_hready_nxt = 1'b1;
        w_hresp_nxt  = RESP_OKAY;
        case (w_state_nxt)
            ST_ERR1: begin
                w_hready_nxt = 1'b0;
                w_hresp_nxt  = RESP_ERROR;
            end
            ST_ERR2: begin
                w_hready_nxt = 1'b1;
                w_hresp_nxt  = RESP_ERROR;
            end
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
                w_hready_nxt = 1'b0;
                w_hresp_nxt  = RESP_OKAY;
            end
`endif
            default: begin
                w_hready_nxt = 1'b1;
                w_hresp_nxt  = RESP_OKAY;
            end
        endcase
    end

    // Control state, address-phase capture and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_addr   <= {ADDR_LG{1'b0}};
            r_write  <= 1'b0;
            r_size   <= 3'd0;
            r_hready <= 1'b1;
            r_hresp  <= RESP_OKAY;
            r_hrdata <= {DW{1'b0}};
`ifdef AHB_SLV_WAIT_EN
            r_wait_cnt <= {WCW{1'b0}};
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_hready <= w_hready_nxt;
            r_hresp  <= w_hresp_nxt;
            r_hrdata <= w_hrdata_nxt;
`ifdef AHB_SLV_WAIT_EN
            r_wait_cnt <= w_wait_cnt_nxt;
`endif
            if (w_accept) begin
                r_addr  <= haddr[ADDR_LG-1:0];
                r_write <= hwrite;
                r_size  <= hsize;
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (resetn && w_wr_en) begin
            r_mem[w_wr_idx] <= f_merge(r_mem[w_wr_idx], hwdata, w_wr_mask);
        end
    end

    assign hrdata = r_hrdata;
    assign hready = r_hready;
    assign hresp  = r_hresp;

endmodule
